sram_port_arbiter: RTL

Two-requester arbiter and sequencer for one single-port SoC SRAM macro (ICCM/DCCM class: active-low chip select and write enable, byte write mask, macro clocked on the inverted system clock). Port 0 serves the UART program loader (iccm controller write path). Port 1 serves the TL-UL memory adapter. The block selects at most one access per cycle, drives the macro, and returns read data to the winning port one cycle later. A starvation guard and a loader lock bound the arbitration.

---
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port SRAM macro (active-low csb/web, byte mask).
// Define SRAM_ARB_RR_EN for round-robin on contention; default is fixed priority to port 0.
module sram_port_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            p0_req_i,
    input  logic            p0_we_i,
    input  logic [AW-1:0]   p0_addr_i,
    input  logic [DW-1:0]   p0_wdata_i,
    input  logic [DW/8-1:0] p0_wmask_i,
    output logic            p0_gnt_o,
    output logic            p0_rvalid_o,
    output logic [DW-1:0]   p0_rdata_o,
    input  logic            p0_lock_i,
    input  logic            p1_req_i,
    input  logic            p1_we_i,
    input  logic [AW-1:0]   p1_addr_i,
    input  logic [DW-1:0]   p1_wdata_i,
    input  logic [DW/8-1:0] p1_wmask_i,
    output logic            p1_gnt_o,
    output logic            p1_rvalid_o,
    output logic [DW-1:0]   p1_rdata_o,
    output logic            sram_csb_o,
    output logic            sram_web_o,
    output logic [DW/8-1:0] sram_wmask_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_din_o,
    input  logic [DW-1:0]   sram_dout_i
);

    localparam int MW = DW / 8;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [1:0]    rd_pend_reg, rd_pend_next;
    logic [7:0]    wait_cnt_reg, wait_cnt_next;
    logic          last_w_reg;

    logic          win_valid, win_port;
    logic          starve;
    logic [1:0]    req, we;
    logic [AW-1:0] addr_a  [2];
    logic [DW-1:0] wdata_a [2];
    logic [MW-1:0] wmask_a [2];
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata   [2];

    assign req        = {p1_req_i, p0_req_i};
    assign we         = {p1_we_i, p0_we_i};
    assign addr_a[0]  = p0_addr_i;
    assign addr_a[1]  = p1_addr_i;
    assign wdata_a[0] = p0_wdata_i;
    assign wdata_a[1] = p1_wdata_i;
    assign wmask_a[0] = p0_wmask_i;
    assign wmask_a[1] = p1_wmask_i;

    assign starve = (wait_cnt_reg == WAIT_MAX);

    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (rst_i) begin
            win_valid = 1'b0;
        end else if (p0_lock_i) begin
            win_valid = p0_req_i;
            win_port  = 1'b0;
        end else if (starve && p1_req_i) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end else if (p0_req_i && p1_req_i) begin
            win_valid = 1'b1;
`ifdef SRAM_ARB_RR_EN
            win_port  = ~last_w_reg;
`else
            win_port  = 1'b0;
`endif
        end else if (p0_req_i) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (p1_req_i) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end
    end

    assign gnt[0]   = win_valid & ~win_port;
    assign gnt[1]   = win_valid & win_port;
    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];

    assign sram_csb_o   = ~win_valid;
    assign sram_web_o   = ~(win_valid & we[win_port]);
    assign sram_addr_o  = win_valid ? addr_a[win_port]  : '0;
    assign sram_din_o   = win_valid ? wdata_a[win_port] : '0;
    assign sram_wmask_o = win_valid ? wmask_a[win_port] : '0;

    // Clear wins over hold: an idle or served port 1 never carries stale wait credit.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (gnt[1] || !p1_req_i) begin
            wait_cnt_next = 8'd0;
        end else if (p0_lock_i) begin
            wait_cnt_next = wait_cnt_reg;
        end else if (wait_cnt_reg < WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_reg  <= 2'b00;
            wait_cnt_reg <= 8'd0;
            last_w_reg   <= 1'b1;
        end else begin
            rd_pend_reg  <= rd_pend_next;
            wait_cnt_reg <= wait_cnt_next;
            if (win_valid) begin
                last_w_reg <= win_port;
            end
        end
    end

    // A pending read is suppressed during reset so it is never delivered across it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign rd_pend_next[gi] = gnt[gi] & ~we[gi];
            assign rvalid[gi]       = rd_pend_reg[gi] & ~rst_i;
            assign rdata[gi]        = rvalid[gi] ? sram_dout_i : '0;
        end
    endgenerate

    assign p0_rvalid_o = rvalid[0];
    assign p1_rvalid_o = rvalid[1];
    assign p0_rdata_o  = rdata[0];
    assign p1_rdata_o  = rdata[1];

endmodule
